// File: rtl/iter_divider.sv
// Iterative restoring divider for signed or unsigned operands.
// The divider produces one quotient bit per cycle and uses a final fix-up cycle to apply signs.
// A zero divisor, and the signed overflow case, bypass the iteration loop.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; operands are captured on accept
// S_CALC | shift-subtract steps; exits early for zero divisor/overflow
// S_FIX  | apply quotient/remainder signs to the magnitudes
// S_DONE | result valid; held until out_ready_i
module iter_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_pr;
  logic [WIDTH-1:0]     r_dvsr;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic                 r_zero_case;
  logic                 r_ovf_case;
  logic [WIDTH-1:0]     r_quot;
  logic [WIDTH-1:0]     r_remd;
  logic                 r_dz;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_zero;
  logic                 w_ovf;
  logic [WIDTH:0]       w_minuend;
  logic                 w_neg;
  logic [WIDTH-1:0]     w_diff_lo;
  logic [2*WIDTH-1:0]   w_pr_step;
  logic [WIDTH-1:0]     w_q_raw;
  logic [WIDTH-1:0]     w_r_raw;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;

  assign w_a_neg = signed_i & dividend_i[WIDTH-1];
  assign w_b_neg = signed_i & divisor_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_mag = w_b_neg ? -divisor_i : divisor_i;
  assign w_zero  = (divisor_i == '0);
  assign w_ovf   = signed_i & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor_i == '1);

  // The upper half shifted left by one, plus the next dividend bit, is the WIDTH+1-bit trial value.
  // When the subtraction succeeds, the result is below the divisor.
  // Therefore only the low WIDTH bits of the difference need to be kept.
  assign w_minuend = r_pr[2*WIDTH-1:WIDTH-1];
  assign w_neg     = (w_minuend < {1'b0, r_dvsr});
  assign w_diff_lo = w_minuend[WIDTH-1:0] - r_dvsr;
  assign w_pr_step = w_neg ? {r_pr[2*WIDTH-2:0], 1'b0}
                           : {w_diff_lo, r_pr[WIDTH-2:0], 1'b1};

  assign w_q_raw = r_pr[WIDTH-1:0];
  assign w_r_raw = r_pr[2*WIDTH-1:WIDTH];
  assign w_q_fix = r_q_neg ? -w_q_raw : w_q_raw;
  assign w_r_fix = r_r_neg ? -w_r_raw : w_r_raw;

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign quotient_o  = r_quot;
  assign remainder_o = r_remd;
  assign div_zero_o  = r_dz;

  // State register; reset wins over any accept or consume.
  always_ff @(posedge clk) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid_i) w_state_nxt = S_CALC;
      S_CALC: begin
        if (r_zero_case || r_ovf_case) w_state_nxt = S_DONE;
        else if (r_cnt == '0)          w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cnt       <= '0;
      r_pr        <= '0;
      r_dvsr      <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_zero_case <= 1'b0;
      r_ovf_case  <= 1'b0;
      r_quot      <= '0;
      r_remd      <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_cnt       <= CNT_INIT;
            // Bypass cases keep the raw dividend, because they return it unmodified.
            r_pr        <= {{WIDTH{1'b0}}, (w_zero || w_ovf) ? dividend_i : w_a_mag};
            r_dvsr      <= w_b_mag;
            r_q_neg     <= w_a_neg ^ w_b_neg;
            r_r_neg     <= w_a_neg;
            r_zero_case <= w_zero;
            r_ovf_case  <= w_ovf;
          end
        end
        S_CALC: begin
          if (r_zero_case) begin
            r_quot <= '1;
            r_remd <= r_pr[WIDTH-1:0];
            r_dz   <= 1'b1;
          end else if (r_ovf_case) begin
            r_quot <= r_pr[WIDTH-1:0];
            r_remd <= '0;
            r_dz   <= 1'b0;
          end else if (r_cnt != '0) begin
            r_pr  <= w_pr_step;
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_FIX: begin
          r_quot <= w_q_fix;
          r_remd <= w_r_fix;
          r_dz   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
